// File: rtl/pe_propagation_stream.sv
// pe_propagation_stream
// One free-streaming step of an HPP lattice gas, applied to a lattice that arrives
// one column per handshake. A two-column window (left, cur) plus the incoming column
// (right) is enough to build each propagated column. The vertical boundary is
// zero-fill, toroidal wrap, or taken from edge ports so stacked stripes can be chained.

module pe_propagation_stream #(
    parameter int ROWS      = 2,
    parameter int EDGE_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5*ROWS-1:0]   in_data,
    input  logic                in_first,
    input  logic                in_last,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [5*ROWS-1:0]   out_data,
    output logic                out_first,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                from_north_s,
    input  logic                from_south_n,
    output logic                to_north_n,
    output logic                to_south_s,
    output logic [CNT_W-1:0]    frame_count,
    output logic                protocol_err
);

    localparam int DW = 5 * ROWS;

    typedef enum logic [1:0] {
        EMPTY,
        STREAM,
        FLUSH
    } state_t;

    state_t          state;
    logic [DW-1:0]   left_col;
    logic [DW-1:0]   cur_col;
    logic            first_pend;

    logic            slot_free;
    logic            accept;
    logic [DW-1:0]   right_col;
    logic [DW-1:0]   prop_col;
    logic            edge_n_bottom;
    logic            edge_s_top;

    assign slot_free  = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign right_col  = (state == FLUSH) ? '0 : in_data;
    assign to_north_n = cur_col[1];
    assign to_south_s = cur_col[5*(ROWS-1)+3];

    // Input may only be taken when the propagated column has somewhere to go.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            EMPTY:   in_ready = 1'b1;
            STREAM:  in_ready = slot_free;
            default: in_ready = 1'b0;
        endcase
    end

    // Particles that would cross the top/bottom of the stripe come from here.
    always_comb begin
        edge_n_bottom = 1'b0;
        edge_s_top    = 1'b0;
        if (EDGE_MODE == 1) begin
            edge_n_bottom = cur_col[1];
            edge_s_top    = cur_col[5*(ROWS-1)+3];
        end else if (EDGE_MODE == 2) begin
            edge_n_bottom = from_south_n;
            edge_s_top    = from_north_s;
        end
    end

    // Gather view of streaming: each output bit pulls from its upstream neighbour.
    always_comb begin
        prop_col = '0;
        for (int r = 0; r < ROWS; r++) begin
            prop_col[5*r+0] = left_col[5*r+0];
            prop_col[5*r+2] = right_col[5*r+2];
            prop_col[5*r+4] = cur_col[5*r+4];
        end
        for (int r = 0; r < ROWS - 1; r++) begin
            prop_col[5*r+1]     = cur_col[5*(r+1)+1];
            prop_col[5*(r+1)+3] = cur_col[5*r+3];
        end
        prop_col[5*(ROWS-1)+1] = edge_n_bottom;
        prop_col[3]            = edge_s_top;
    end

    // Window, output register, frame counter and error flag all advance together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= EMPTY;
            left_col     <= '0;
            cur_col      <= '0;
            first_pend   <= 1'b0;
            out_data     <= '0;
            out_first    <= 1'b0;
            out_last     <= 1'b0;
            out_valid    <= 1'b0;
            frame_count  <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        if (in_first) begin
                            cur_col    <= in_data;
                            left_col   <= '0;
                            first_pend <= 1'b1;
                            state      <= in_last ? FLUSH : STREAM;
                        end else begin
                            protocol_err <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (in_first) begin
                            protocol_err <= 1'b1;
                            cur_col      <= in_data;
                            left_col     <= '0;
                            first_pend   <= 1'b1;
                            state        <= in_last ? FLUSH : STREAM;
                        end else begin
                            out_data   <= prop_col;
                            out_first  <= first_pend;
                            out_last   <= 1'b0;
                            out_valid  <= 1'b1;
                            left_col   <= cur_col;
                            cur_col    <= in_data;
                            first_pend <= 1'b0;
                            if (in_last) begin
                                state <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        out_data    <= prop_col;
                        out_first   <= first_pend;
                        out_last    <= 1'b1;
                        out_valid   <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                        state       <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_propagation_stream.sv
// tb_pe_propagation_stream
// Drives the same column stream into three instances (zero-fill, wrap, edge ports)
// and compares every output transfer with a frame-level scatter model of particle motion.

module tb_pe_propagation_stream;

    localparam int ROWS = 2;
    localparam int DW   = 5 * ROWS;

    logic           clk = 1'b0;
    logic           reset;
    logic [DW-1:0]  in_data;
    logic           in_first, in_last, in_valid, out_ready;
    logic           from_north_s, from_south_n;

    logic [DW-1:0]  od [3];
    logic           of [3];
    logic           ol [3];
    logic           ov [3];
    logic           ir [3];
    logic           tn [3];
    logic           ts [3];
    logic           pe [3];
    logic [15:0]    fc [3];

    logic [11:0]    q0 [$];
    logic [11:0]    q1 [$];
    logic [11:0]    q2 [$];

    logic [DW-1:0]  frm [16];
    int             nfrm;
    logic [DW-1:0]  held_col;
    bit             in_frame;
    bit             accepted;
    bit             rand_ready;
    int             frames_done;
    int             pop_acc;
    int             pop_in;
    int             checks = 0;
    int             errors = 0;

    // Free-running clock
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pe_propagation_stream #(
            .ROWS(ROWS),
            .EDGE_MODE(g),
            .CNT_W(16)
        ) dut (
            .clk(clk),
            .reset(reset),
            .in_data(in_data),
            .in_first(in_first),
            .in_last(in_last),
            .in_valid(in_valid),
            .in_ready(ir[g]),
            .out_data(od[g]),
            .out_first(of[g]),
            .out_last(ol[g]),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .from_north_s(from_north_s),
            .from_south_n(from_south_n),
            .to_north_n(tn[g]),
            .to_south_s(ts[g]),
            .frame_count(fc[g]),
            .protocol_err(pe[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pushQ(input int m, input logic [11:0] v);
        case (m)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    // Scatter model: every particle in frm is moved to its destination cell
    task automatic pushExpected(input int m, input int drop_last);
        logic [DW-1:0] res [16];
        for (int c = 0; c < nfrm; c++) begin
            res[c] = '0;
            for (int r = 0; r < ROWS; r++) res[c][5*r+4] = frm[c][5*r+4];
        end
        for (int c = 0; c < nfrm; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (frm[c][5*r+0] && (c + 1 < nfrm)) res[c+1][5*r+0] = 1'b1;
                if (frm[c][5*r+2] && (c > 0))        res[c-1][5*r+2] = 1'b1;
                if (frm[c][5*r+1]) begin
                    if (r > 0)        res[c][5*(r-1)+1] = 1'b1;
                    else if (m == 1)  res[c][5*(ROWS-1)+1] = 1'b1;
                end
                if (frm[c][5*r+3]) begin
                    if (r < ROWS - 1) res[c][5*(r+1)+3] = 1'b1;
                    else if (m == 1)  res[c][3] = 1'b1;
                end
            end
        end
        if (m == 2) begin
            for (int c = 0; c < nfrm; c++) begin
                res[c][3]             = from_north_s;
                res[c][5*(ROWS-1)+1]  = from_south_n;
            end
        end
        for (int c = 0; c < nfrm - drop_last; c++) begin
            pushQ(m, {res[c], (c == 0), (c == nfrm - 1)});
        end
    endtask

    task automatic checkOutput(input int i);
        logic [11:0] exp_v;
        exp_v = 'x;
        case (i)
            0:       if (q0.size() > 0) exp_v = q0.pop_front();
            1:       if (q1.size() > 0) exp_v = q1.pop_front();
            default: if (q2.size() > 0) exp_v = q2.pop_front();
        endcase
        if (i == 1) pop_acc += $countones(od[1]);
        check($sformatf("out_mode%0d", i), {20'd0, od[i], of[i], ol[i]}, {20'd0, exp_v});
    endtask

    // One clock of stimulus; output transfers are scored at the falling edge
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                 input logic f, input logic l, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_first  = f;
        in_last   = l;
        out_ready = ordy;
        @(negedge clk);
        accepted = v && ir[0];
        for (int i = 0; i < 3; i++) begin
            if (ov[i] && out_ready) checkOutput(i);
        end
        @(posedge clk);
        #1;
        if (accepted && (f || in_frame)) begin
            held_col = d;
            if (f) in_frame = !l;
            else if (l) in_frame = 1'b0;
            if (l) frames_done++;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("to_north_n%0d", i), tn[i], held_col[1]);
                check($sformatf("to_south_s%0d", i), ts[i], held_col[5*(ROWS-1)+3]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic sendColumn(input logic [DW-1:0] d, input logic f, input logic l);
        logic ordy;
        accepted = 1'b0;
        for (int k = 0; k < 100; k++) begin
            ordy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            applyStimulus(1'b1, d, f, l, ordy);
            if (accepted) break;
        end
        check("accept_timeout", {31'd0, accepted}, 32'd1);
    endtask

    task automatic drain();
        logic ordy;
        for (int k = 0; k < 200; k++) begin
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 &&
                !ov[0] && !ov[1] && !ov[2]) break;
            ordy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            applyStimulus(1'b0, '0, 1'b0, 1'b0, ordy);
        end
        check("drain_empty", q0.size() + q1.size() + q2.size(), 32'd0);
    endtask

    task automatic checkFrameCount();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("frame_count%0d", i), {16'd0, fc[i]}, frames_done);
        end
    endtask

    task automatic sendFrame();
        for (int m = 0; m < 3; m++) pushExpected(m, 0);
        for (int c = 0; c < nfrm; c++) sendColumn(frm[c], (c == 0), (c == nfrm - 1));
        drain();
        checkFrameCount();
    endtask

    task automatic clearModel();
        q0.delete();
        q1.delete();
        q2.delete();
        in_frame    = 1'b0;
        held_col    = '0;
        frames_done = 0;
    endtask

    // Watchdog so a stuck handshake still ends the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence of scenarios
    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_data = '0; in_first = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; from_north_s = 1'b0; from_south_n = 1'b0;
        rand_ready = 1'b0; pop_acc = 0; pop_in = 0; accepted = 1'b0;
        clearModel();
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_out_valid%0d", i), ov[i], 0);
            check($sformatf("rst_in_ready%0d", i), ir[i], 1);
            check($sformatf("rst_perr%0d", i), pe[i], 0);
            check($sformatf("rst_out%0d", i), {od[i], of[i], ol[i]}, 0);
        end
        checkFrameCount();
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        // E shift, zero-fill
        nfrm = 3; frm[0] = 10'h001; frm[1] = 10'h000; frm[2] = 10'h000;
        sendFrame();
        // W shift
        nfrm = 2; frm[0] = 10'h000; frm[1] = 10'h080;
        sendFrame();
        // Vertical wrap on a single-column frame
        nfrm = 1; frm[0] = 10'h002;
        sendFrame();

        // Backpressure mid-frame on a frame whose particles cannot leave horizontally
        nfrm = 8;
        for (int c = 0; c < 8; c++) frm[c] = DW'($urandom);
        frm[7] = frm[7] & ~10'h021;
        frm[0] = frm[0] & ~10'h084;
        pop_in = 0;
        for (int c = 0; c < 8; c++) pop_in += $countones(frm[c]);
        pop_acc = 0;
        for (int m = 0; m < 3; m++) pushExpected(m, 0);
        for (int c = 0; c < 5; c++) sendColumn(frm[c], (c == 0), 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, frm[5], 1'b0, 1'b0, 1'b0);
            check("bp_no_accept", {31'd0, accepted}, 32'd0);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp_in_ready%0d", i), ir[i], 0);
                check($sformatf("bp_out_valid%0d", i), ov[i], 1);
            end
            check("bp_hold_data", od[1], q1[0][11:2]);
        end
        rand_ready = 1'b1;
        for (int c = 5; c < 8; c++) sendColumn(frm[c], 1'b0, (c == 7));
        drain();
        checkFrameCount();
        check("mode1_popcount", pop_acc, pop_in);

        // Random frames with random backpressure and random edge-port inputs
        for (int f = 0; f < 6; f++) begin
            nfrm = $urandom_range(1, 6);
            for (int c = 0; c < nfrm; c++) frm[c] = DW'($urandom);
            from_north_s = 1'($urandom);
            from_south_n = 1'($urandom);
            sendFrame();
        end
        from_north_s = 1'b0;
        from_south_n = 1'b0;

        // in_first while streaming: old window dropped without a last column
        nfrm = 2;
        frm[0] = DW'($urandom);
        frm[1] = DW'($urandom);
        for (int m = 0; m < 3; m++) pushExpected(m, 1);
        sendColumn(frm[0], 1'b1, 1'b0);
        sendColumn(frm[1], 1'b0, 1'b0);
        nfrm = 3;
        for (int c = 0; c < 3; c++) frm[c] = DW'($urandom);
        sendFrame();
        for (int i = 0; i < 3; i++) check($sformatf("perr_set%0d", i), pe[i], 1);

        // Asynchronous reset in the middle of a frame with a held output
        rand_ready = 1'b0;
        applyStimulus(1'b1, 10'h155, 1'b1, 1'b0, 1'b0);
        check("mid_accept0", {31'd0, accepted}, 32'd1);
        applyStimulus(1'b1, 10'h2AA, 1'b0, 1'b0, 1'b0);
        check("mid_accept1", {31'd0, accepted}, 32'd1);
        check("mid_out_valid", ov[0], 1);
        #1 reset = 1'b1;
        #1;
        clearModel();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async_out_valid%0d", i), ov[i], 0);
            check($sformatf("async_perr%0d", i), pe[i], 0);
            check($sformatf("async_to_north%0d", i), tn[i], 0);
            check($sformatf("async_in_ready%0d", i), ir[i], 1);
        end
        checkFrameCount();
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        // Column without in_first while idle is dropped and flagged
        applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("drop_perr%0d", i), pe[i], 1);
            check($sformatf("drop_to_north%0d", i), tn[i], 0);
            check($sformatf("drop_out_valid%0d", i), ov[i], 0);
        end

        // A normal frame completes after the reset
        rand_ready = 1'b1;
        nfrm = 4;
        for (int c = 0; c < 4; c++) frm[c] = DW'($urandom);
        sendFrame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
